// File: rtl/calc_pkg.sv
// Shared types for the calculator request sequencer: commands, responses,
// sequencer FSM states and the latched transaction payload.
package calc_pkg;

   localparam int unsigned CMD_W  = 4;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned RESP_W = 2;
   localparam int unsigned CNT_W  = 8;

   typedef enum logic [CMD_W-1:0] {
      CMD_NOP = 4'd0,
      CMD_ADD = 4'd1,
      CMD_SUB = 4'd2,
      CMD_SHL = 4'd5,
      CMD_SHR = 4'd6
   } cmd_e;

   typedef enum logic [RESP_W-1:0] {
      RESP_NONE = 2'd0,
      RESP_OK   = 2'd1,
      RESP_OVF  = 2'd2,
      RESP_ERR  = 2'd3
   } resp_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND1,
      ST_SEND2,
      ST_WAIT,
      ST_HOLD
   } state_e;

   typedef struct packed {
      logic [CMD_W-1:0]  cmd;
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
   } txn_t;

   // Saturating increment for the wait counter; it must never wrap.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/calc_req_sequencer_if.sv
// Request/response handshake bundle between a client and calc_req_sequencer.
interface calc_req_sequencer_if;
   import calc_pkg::*;

   logic                  req_valid;
   logic                  req_ready;
   logic [CMD_W-1:0]      req_cmd;
   logic [DATA_W-1:0]     req_op1;
   logic [DATA_W-1:0]     req_op2;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [RESP_W-1:0]     rsp_code;
   logic [DATA_W-1:0]     rsp_data;
   logic                  rsp_timeout;
   logic [CNT_W-1:0]      rsp_latency;

   // Sequencer side
   modport slave (
      input  req_valid, req_cmd, req_op1, req_op2, rsp_ready,
      output req_ready, rsp_valid, rsp_code, rsp_data, rsp_timeout, rsp_latency
   );

   // Client side
   modport master (
      output req_valid, req_cmd, req_op1, req_op2, rsp_ready,
      input  req_ready, rsp_valid, rsp_code, rsp_data, rsp_timeout, rsp_latency
   );

endinterface

// File: rtl/calc_golden.sv
// Combinational expected-result model for one calculator transaction.
// Only compiled when CALC_SEQ_CHECK_EN is defined.
`ifdef CALC_SEQ_CHECK_EN
module calc_golden
   import calc_pkg::*;
(
   input  txn_t              txn,
   output logic [RESP_W-1:0] exp_code,
   output logic [DATA_W-1:0] exp_data
);

   logic [DATA_W:0] sum;

   assign sum = {1'b0, txn.op1} + {1'b0, txn.op2};

   always_comb begin
      exp_code = RESP_ERR;
      exp_data = '0;
      case (txn.cmd)
         CMD_NOP: begin
            // A no-op never answers, so the correct outcome is a timeout.
            exp_code = RESP_NONE;
         end
         CMD_ADD: begin
            if (sum[DATA_W]) begin
               exp_code = RESP_OVF;
            end else begin
               exp_code = RESP_OK;
               exp_data = sum[DATA_W-1:0];
            end
         end
         CMD_SUB: begin
            if (txn.op2 > txn.op1) begin
               exp_code = RESP_OVF;
            end else begin
               exp_code = RESP_OK;
               exp_data = txn.op1 - txn.op2;
            end
         end
         CMD_SHL: begin
            exp_code = RESP_OK;
            exp_data = txn.op1 << txn.op2[4:0];
         end
         CMD_SHR: begin
            exp_code = RESP_OK;
            exp_data = txn.op1 >> txn.op2[4:0];
         end
         default: begin
            exp_code = RESP_ERR;
         end
      endcase
   end

endmodule
`endif

// File: rtl/calc_req_sequencer.sv
// Serialises one calculator transaction onto the two-cycle port protocol and
// returns the response with latency/timeout; CALC_SEQ_CHECK_EN adds a result checker.
module calc_req_sequencer
   import calc_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 10
)(
   input  logic               c_clk,
   input  logic               reset,
   calc_req_sequencer_if.slave bus,
   output logic [CMD_W-1:0]   cmd_out,
   output logic [DATA_W-1:0]  data_out,
   input  logic [RESP_W-1:0]  resp_in,
   input  logic [DATA_W-1:0]  data_in,
   output logic               spurious,
   output logic               chk_err
);

   localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYCLES);

   state_e              state, state_n;
   txn_t                txn, txn_n;
   logic [CNT_W-1:0]    cnt, cnt_n, cnt_cur;

   logic [CMD_W-1:0]    cmd_n;
   logic [DATA_W-1:0]   data_n;
   logic                spurious_n;

   logic                req_ready_q, req_ready_n;
   logic                rsp_valid_q, rsp_valid_n;
   logic [RESP_W-1:0]   rsp_code_q, rsp_code_n;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_n;
   logic                rsp_timeout_q, rsp_timeout_n;
   logic [CNT_W-1:0]    rsp_latency_q, rsp_latency_n;

   assign cnt_cur = sat_inc(cnt);

   assign bus.req_ready   = req_ready_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_code    = rsp_code_q;
   assign bus.rsp_data    = rsp_data_q;
   assign bus.rsp_timeout = rsp_timeout_q;
   assign bus.rsp_latency = rsp_latency_q;

   // Next state plus next values of every registered output.
   always_comb begin
      state_n       = state;
      txn_n         = txn;
      cnt_n         = cnt;
      cmd_n         = '0;
      data_n        = '0;
      rsp_code_n    = rsp_code_q;
      rsp_data_n    = rsp_data_q;
      rsp_timeout_n = rsp_timeout_q;
      rsp_latency_n = rsp_latency_q;
      spurious_n    = (resp_in != '0) && (state != ST_WAIT);

      case (state)
         ST_IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               txn_n.cmd = bus.req_cmd;
               txn_n.op1 = bus.req_op1;
               txn_n.op2 = bus.req_op2;
               cmd_n     = bus.req_cmd;
               data_n    = bus.req_op1;
               state_n   = ST_SEND1;
            end
         end
         ST_SEND1: begin
            data_n  = txn.op2;
            state_n = ST_SEND2;
         end
         ST_SEND2: begin
            cnt_n   = '0;
            state_n = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_n = cnt_cur;
            // A response in the final allowed cycle wins over the timeout.
            if (resp_in != '0) begin
               rsp_code_n    = resp_in;
               rsp_data_n    = data_in;
               rsp_latency_n = cnt_cur;
               rsp_timeout_n = 1'b0;
               state_n       = ST_HOLD;
            end else if (cnt_cur >= TIMEOUT_V) begin
               rsp_code_n    = RESP_NONE;
               rsp_data_n    = '0;
               rsp_latency_n = TIMEOUT_V;
               rsp_timeout_n = 1'b1;
               state_n       = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (bus.rsp_ready) begin
               state_n = ST_IDLE;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase

      req_ready_n = (state_n == ST_IDLE);
      rsp_valid_n = (state_n == ST_HOLD);
   end

   always_ff @(posedge c_clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge c_clk) begin
      if (reset) begin
         txn           <= '0;
         cnt           <= '0;
         cmd_out       <= '0;
         data_out      <= '0;
         spurious      <= 1'b0;
         req_ready_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_code_q    <= '0;
         rsp_data_q    <= '0;
         rsp_timeout_q <= 1'b0;
         rsp_latency_q <= '0;
      end else begin
         txn           <= txn_n;
         cnt           <= cnt_n;
         cmd_out       <= cmd_n;
         data_out      <= data_n;
         spurious      <= spurious_n;
         req_ready_q   <= req_ready_n;
         rsp_valid_q   <= rsp_valid_n;
         rsp_code_q    <= rsp_code_n;
         rsp_data_q    <= rsp_data_n;
         rsp_timeout_q <= rsp_timeout_n;
         rsp_latency_q <= rsp_latency_n;
      end
   end

`ifdef CALC_SEQ_CHECK_EN
   logic [RESP_W-1:0] exp_code;
   logic [DATA_W-1:0] exp_data;
   logic              chk_q, chk_n;

   calc_golden u_golden (
      .txn      (txn),
      .exp_code (exp_code),
      .exp_data (exp_data)
   );

   // Verdict is formed on entry to HOLD and lives only as long as HOLD.
   always_comb begin
      chk_n = (state_n == ST_HOLD) ? chk_q : 1'b0;
      if ((state == ST_WAIT) && (state_n == ST_HOLD)) begin
         chk_n = (rsp_code_n != exp_code) ||
                 ((rsp_code_n == RESP_OK) && (rsp_data_n != exp_data));
      end
   end

   always_ff @(posedge c_clk) begin
      if (reset) begin
         chk_q <= 1'b0;
      end else begin
         chk_q <= chk_n;
      end
   end

   assign chk_err = chk_q;
`else
   assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_calc_req_sequencer.sv
// Self-checking bench for calc_req_sequencer: directed scenarios plus random
// transactions compared against a transaction-level reference model.
module tb_calc_req_sequencer;
   import calc_pkg::*;

   localparam int unsigned TO = 10;

`ifdef CALC_SEQ_CHECK_EN
   localparam bit CHK_ON = 1'b1;
`else
   localparam bit CHK_ON = 1'b0;
`endif

   logic        c_clk = 1'b0;
   logic        reset;
   logic [3:0]  cmd_out;
   logic [31:0] data_out;
   logic [1:0]  resp_in;
   logic [31:0] data_in;
   logic        spurious;
   logic        chk_err;

   calc_req_sequencer_if bus();

   calc_req_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
      .c_clk    (c_clk),
      .reset    (reset),
      .bus      (bus),
      .cmd_out  (cmd_out),
      .data_out (data_out),
      .resp_in  (resp_in),
      .data_in  (data_in),
      .spurious (spurious),
      .chk_err  (chk_err)
   );

   always #5 c_clk = ~c_clk;

   int cyc = 0;
   always @(posedge c_clk) cyc <= cyc + 1;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [1:0]  last_code;
   bit          chain;
   int          next_accept;

   task automatic tick();
      @(posedge c_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Calculator result rules computed with wide plain arithmetic.
   function automatic void golden(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [1:0] code, output logic [31:0] d);
      logic [63:0] wide;
      logic [4:0]  sh;
      sh   = b[4:0];
      code = 2'd3;
      d    = 32'd0;
      case (c)
         4'd0: code = 2'd0;
         4'd1: begin
            wide = 64'(a) + 64'(b);
            if (wide > 64'h0000_0000_FFFF_FFFF) code = 2'd2;
            else begin code = 2'd1; d = wide[31:0]; end
         end
         4'd2: begin
            if (b > a) code = 2'd2;
            else begin code = 2'd1; d = a - b; end
         end
         4'd5: begin code = 2'd1; d = a << sh; end
         4'd6: begin code = 2'd1; d = a >> sh; end
         default: code = 2'd3;
      endcase
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req_ready"},   32'(bus.req_ready),   32'd0);
      chk({tag, "_rsp_valid"},   32'(bus.rsp_valid),   32'd0);
      chk({tag, "_rsp_code"},    32'(bus.rsp_code),    32'd0);
      chk({tag, "_rsp_data"},    bus.rsp_data,         32'd0);
      chk({tag, "_rsp_timeout"}, 32'(bus.rsp_timeout), 32'd0);
      chk({tag, "_rsp_latency"}, 32'(bus.rsp_latency), 32'd0);
      chk({tag, "_cmd_out"},     32'(cmd_out),         32'd0);
      chk({tag, "_data_out"},    data_out,             32'd0);
      chk({tag, "_spurious"},    32'(spurious),        32'd0);
      chk({tag, "_chk_err"},     32'(chk_err),         32'd0);
   endtask

   task automatic chk_hold(input logic [1:0] ecode, input logic [31:0] edata, input int lat,
                           input logic etmo, input logic echk);
      chk("hold_rsp_valid",   32'(bus.rsp_valid),   32'd1);
      chk("hold_req_ready",   32'(bus.req_ready),   32'd0);
      chk("hold_rsp_code",    32'(bus.rsp_code),    32'(ecode));
      chk("hold_rsp_data",    bus.rsp_data,         edata);
      chk("hold_rsp_latency", 32'(bus.rsp_latency), 32'(lat));
      chk("hold_rsp_timeout", 32'(bus.rsp_timeout), 32'(etmo));
      chk("hold_chk_err",     32'(chk_err),         32'(echk));
      chk("hold_cmd_out",     32'(cmd_out),         32'd0);
   endtask

   // One full transaction: rc is the WAIT cycle the port answers in (0 = silent).
   task automatic run_txn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input int rc, input logic [1:0] rcode, input logic [31:0] rdata,
                          input int hold);
      int          lat;
      int          acc;
      logic [1:0]  ecode, gcode;
      logic [31:0] edata, gdata;
      logic        etmo, echk;

      if (rc >= 1 && rc <= int'(TO) && rcode != 2'd0) begin
         lat = rc; ecode = rcode; edata = rdata; etmo = 1'b0;
      end else begin
         lat = int'(TO); ecode = 2'd0; edata = 32'd0; etmo = 1'b1;
      end
      golden(c, a, b, gcode, gdata);
      echk = CHK_ON && ((ecode != gcode) || (ecode == 2'd1 && edata != gdata));

      chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_cmd   = c;
      bus.req_op1   = a;
      bus.req_op2   = b;
      tick();
      acc = cyc;
      bus.req_valid = 1'b0;
      if (chain) chk("req_period", 32'(acc), 32'(next_accept));
      chk("send1_cmd",  32'(cmd_out), 32'(c));
      chk("send1_data", data_out, a);
      chk("send1_req_ready", 32'(bus.req_ready), 32'd0);
      tick();
      chk("send2_cmd",  32'(cmd_out), 32'd0);
      chk("send2_data", data_out, b);
      tick();
      chk("wait_cmd",  32'(cmd_out), 32'd0);
      chk("wait_data", data_out, 32'd0);

      for (int k = 1; k <= lat; k++) begin
         chk("wait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         resp_in = (k == rc) ? rcode : 2'd0;
         data_in = (k == rc) ? rdata : $urandom;
         tick();
         resp_in = 2'd0;
      end
      chk_hold(ecode, edata, lat, etmo, echk);
      chk("hold_spurious", 32'(spurious), 32'd0);

      for (int h = 0; h < hold; h++) begin
         bus.rsp_ready = 1'b0;
         bus.req_valid = 1'b1;
         bus.req_cmd   = 4'($urandom);
         bus.req_op1   = $urandom;
         tick();
         chk_hold(ecode, edata, lat, etmo, echk);
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b0;
      chk("ret_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("ret_req_ready", 32'(bus.req_ready), 32'd1);

      last_code   = ecode;
      chain       = 1'b1;
      next_accept = acc + 4 + lat + hold;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  cmd_tab [10];
      logic [3:0]  c;
      logic [31:0] a, b, rdata;
      logic [1:0]  gcode, rcode;
      logic [31:0] gdata;
      int          rc;

      cmd_tab = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd4, 4'd7, 4'd9, 4'd15};
      chain         = 1'b0;
      last_code     = 2'd0;
      reset         = 1'b1;
      resp_in       = 2'd0;
      data_in       = 32'd0;
      bus.req_valid = 1'b0;
      bus.req_cmd   = 4'd0;
      bus.req_op1   = 32'd0;
      bus.req_op2   = 32'd0;
      bus.rsp_ready = 1'b0;

      tick();
      tick();
      chk_all_zero("reset");
      reset = 1'b0;
      tick();
      chk("post_reset_req_ready", 32'(bus.req_ready), 32'd1);

      // Add 5+1, port answers in WAIT cycle 3
      run_txn(4'd1, 32'd5, 32'd1, 3, 2'd1, 32'd6, 0);

      // Spurious response while idle
      chain   = 1'b0;
      resp_in = 2'd1;
      data_in = 32'hDEAD_BEEF;
      tick();
      resp_in = 2'd0;
      chk("spur_pulse",     32'(spurious),      32'd1);
      chk("spur_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("spur_no_capture", 32'(bus.rsp_code), 32'(last_code));
      chk("spur_req_ready", 32'(bus.req_ready), 32'd1);
      tick();
      chk("spur_clear",     32'(spurious),      32'd0);

      // Overflowing add: correct answer, then a wrong answer
      chain = 1'b0;
      run_txn(4'd1, 32'hFFFF_FFFF, 32'd1, 2, 2'd2, 32'd0, 0);
      run_txn(4'd1, 32'hFFFF_FFFF, 32'd1, 2, 2'd1, 32'd0, 0);

      // No-op with a silent port times out
      run_txn(4'd0, $urandom, $urandom, 0, 2'd0, 32'd0, 0);

      // Consumer stalls 3 cycles, then the next request follows immediately
      run_txn(4'd2, 32'd9, 32'd4, 1, 2'd1, 32'd5, 3);
      run_txn(4'd1, 32'd1, 32'd2, 1, 2'd1, 32'd3, 0);
      run_txn(4'd6, 32'h80, 32'd3, 1, 2'd1, 32'h10, 0);

      // Reset during WAIT cycle 2 drops the transaction
      chain         = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_cmd   = 4'd5;
      bus.req_op1   = 32'd3;
      bus.req_op2   = 32'd2;
      tick();
      bus.req_valid = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      chk_all_zero("mid_wait_reset");
      reset = 1'b0;
      tick();
      chk("rst_exit_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_exit_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      run_txn(4'd5, 32'd3, 32'd2, 2, 2'd1, 32'd12, 0);

      // Random transactions against a well-behaved port, with occasional faults
      for (int i = 0; i < 40; i++) begin
         c = cmd_tab[$urandom_range(0, 9)];
         a = $urandom;
         b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         golden(c, a, b, gcode, gdata);
         if (c == 4'd0) begin
            rc    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
            rcode = (rc != 0) ? 2'd1 : 2'd0;
            rdata = $urandom;
         end else begin
            rc    = $urandom_range(1, 12);
            rcode = gcode;
            rdata = (gcode == 2'd1) ? gdata : $urandom;
            if ($urandom_range(0, 7) == 0) rdata = rdata ^ 32'd1;
            if ($urandom_range(0, 9) == 0) rcode = 2'($urandom_range(1, 3));
         end
         run_txn(c, a, b, rc, rcode, rdata, $urandom_range(0, 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/calc_req_sequencer.md
# calc_req_sequencer

Per-port request sequencer that sits directly upstream of one calculator port of `calc1_top`. It accepts a whole transaction (command, operand 1, operand 2) over a valid/ready handshake and serialises it onto the calculator's two-cycle input protocol. It then waits for the port's response, with a bounded timeout, and returns the result, latency and timeout status over a second valid/ready handshake. One instance drives each of the four calculator ports.

## Interface
- `TIMEOUT_CYCLES`, 10: wait-phase cycles allowed before a timeout is declared; legal range 1..255.
- `c_clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  reset; synchronous, active-high.
- `req_valid`  in  1  transaction offered.
- `req_ready`  out  1  sequencer can accept a transaction.
- `req_cmd`  in  4  calculator command.
- `req_op1`  in  32  operand 1.
- `req_op2`  in  32  operand 2.
- `cmd_out`  out  4  to calculator `reqN_cmd_in`.
- `data_out`  out  32  to calculator `reqN_data_in`.
- `resp_in`  in  2  from calculator `out_respN`.
- `data_in`  in  32  from calculator `out_dataN`.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes result.
- `rsp_code`  out  2  captured response: 0 none, 1 ok, 2 overflow/underflow, 3 invalid command.
- `rsp_data`  out  32  captured data.
- `rsp_timeout`  out  1  no response seen within `TIMEOUT_CYCLES`.
- `rsp_latency`  out  8  number of WAIT cycles up to and including the response cycle.
- `spurious`  out  1  one-cycle pulse when `resp_in` is nonzero outside WAIT.
- `chk_err`  out  1  expected-result mismatch; present only with the checker macro, otherwise tied to 0.

## Operation
- FSM states: IDLE, SEND1, SEND2, WAIT, HOLD.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid` && `req_ready`, latch cmd/op1/op2 and go to SEND1.
- **SEND1** (one cycle)
  - `cmd_out` = cmd, `data_out` = op1.
  - Go to SEND2.
- **SEND2** (one cycle)
  - `cmd_out` = 0, `data_out` = op2.
  - Clear the wait counter; go to WAIT.
- **WAIT**
  - `cmd_out` = 0, `data_out` = 0.
  - Wait counter increments each cycle.
  - First cycle with `resp_in` ≠ 0: capture `resp_in`/`data_in` into `rsp_code`/`rsp_data`, set `rsp_latency` = counter value (1 = first WAIT cycle), `rsp_timeout` = 0, go to HOLD.
  - If the counter reaches `TIMEOUT_CYCLES` with no response: `rsp_code` = 0, `rsp_data` = 0, `rsp_timeout` = 1, `rsp_latency` = `TIMEOUT_CYCLES`, go to HOLD.
- **HOLD**
  - `rsp_valid` = 1; all `rsp_*` outputs stable.
  - On `rsp_ready`, go to IDLE.
  - `req_ready` = 0 throughout; the next request is accepted no earlier than the following cycle.
- `resp_in` ≠ 0 in IDLE, SEND1, SEND2 or HOLD: ignored for capture; pulses `spurious` the next cycle.
- Command 0 (no-op) is sequenced normally. Its correct outcome is a timeout.
- Invalid commands (not 0/1/2/5/6) are forwarded unchanged.

## Timing
- Request accepted at edge T:
  - `cmd_out`/op1 valid T+1.
  - op2 valid T+2.
  - First WAIT sample T+3.
  - `rsp_valid` no earlier than T+4.
- Minimum request-to-request period, with `rsp_ready` held high: 5 cycles.
- Reset (any state, including mid-WAIT), values effective the cycle after the reset edge:
  - State goes to IDLE.
  - `req_ready` = 0 while `reset` is high, 1 the cycle after `reset` falls.
  - All other outputs = 0.
  - A transaction in flight is dropped with no `rsp_valid`.
- Counter is 8 bits and saturates; it never wraps.

## Configuration
- `CALC_SEQ_CHECK_EN` defined: a golden model computes the expected code/data from the latched transaction.
  - add: 33-bit sum carry → 2, else 1 with sum.
  - sub: op2 > op1 → 2, else 1 with op1−op2.
  - shl/shr: 1 with op1 shifted by op2[4:0].
  - nop: expect timeout.
  - other: 3.
  - On entering HOLD, `chk_err` = 1 if the captured code differs, or if the code is 1 and the data differs. Held with HOLD.
  - Data is compared only when code = 1.
- `CALC_SEQ_CHECK_EN` undefined: no model is instantiated; `chk_err` is constant 0.

## Structure
- Shared package `calc_pkg`:
  - Command enum (`CMD_NOP`=0, `CMD_ADD`=1, `CMD_SUB`=2, `CMD_SHL`=5, `CMD_SHR`=6).
  - Response enum (`RESP_NONE`, `RESP_OK`, `RESP_OVF`, `RESP_ERR`).
  - FSM state enum.
  - Transaction struct {cmd, op1, op2}.
- Sub-module `calc_golden`: combinational expected-result model, instantiated only under `CALC_SEQ_CHECK_EN`.

## Test plan
- Add 5+1, port responds 1/6 in WAIT cycle 3 → `rsp_code` 1, `rsp_data` 6, `rsp_latency` 3, `rsp_timeout` 0, `chk_err` 0.
- Add 0xFFFFFFFF+1, port responds 2 → `rsp_code` 2, `chk_err` 0; port forced to respond 1 instead → `chk_err` 1.
- Command 0, port silent → `rsp_valid` at WAIT cycle 10 with `rsp_timeout` 1, `rsp_code` 0, `rsp_latency` 10.
- `rsp_ready` low 3 cycles in HOLD → outputs stable, `req_ready` 0; an offered request is accepted the cycle after return to IDLE.
- Reset asserted in WAIT cycle 2 → next cycle all outputs 0, no `rsp_valid`; shift-left 3 by 2 afterwards → data 12.
- `resp_in` = 1 while IDLE → `spurious` pulses one cycle, no capture.
